// File: rtl/mux5_rr_arbiter.sv
// mux5_rr_arbiter: round-robin arbiter driving the shared 5:1 source mux
// select, with a registered valid/ready output stage.
// Optional build macro: ARB_LOCK_EN (lets a granted requester hold the
// grant across beats via lock[k]); undefined gives pure round-robin.
module mux5_rr_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       req,
    input  logic [4:0]       lock,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    output logic [4:0]       gnt,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [2:0]       ptr;
    logic [4:0]       eff_req;
    logic [2:0]       win;
    logic             free;
    logic             cap;
    logic [WIDTH-1:0] win_data;

    function automatic logic [2:0] inc5(input logic [2:0] k);
        return (k == 3'd4) ? 3'd0 : k + 3'd1;
    endfunction

`ifdef ARB_LOCK_EN
    logic       locked;
    logic [2:0] owner;

    // While locked only the owner's request is visible to the search
    always_comb begin
        eff_req = req;
        if (locked) eff_req = req & (5'b00001 << owner);
    end
`else
    logic lock_unused;
    assign lock_unused = ^lock;

    // Pure round-robin: every request takes part in the search
    always_comb begin
        eff_req = req;
    end
`endif

    assign free = !out_valid || out_ready;
    assign cap  = free && (|eff_req) && !reset;

    // Scan requests from ptr upward, wrapping 4 -> 0; first hit wins
    always_comb begin
        logic       found;
        logic [3:0] s;
        win   = '0;
        found = 1'b0;
        s     = '0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            s = {1'b0, ptr} + 4'(o);
            if (s >= 4'd5) s = s - 4'd5;
            if (!found && eff_req[s[2:0]]) begin
                found = 1'b1;
                win   = s[2:0];
            end
        end
    end

    // Grant and mux select are only asserted on an actual capture
    always_comb begin
        gnt = '0;
        sel = '0;
        if (cap) begin
            gnt = 5'b00001 << win;
            sel = win;
        end
    end

    // Source mux; select codes above 4 never occur
    always_comb begin
        case (win)
            3'd0:    win_data = i0;
            3'd1:    win_data = i1;
            3'd2:    win_data = i2;
            3'd3:    win_data = i3;
            3'd4:    win_data = i4;
            default: win_data = '0;
        endcase
    end

    // Output register, rotation pointer and (optional) lock state
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
`ifdef ARB_LOCK_EN
            locked    <= 1'b0;
            owner     <= '0;
`endif
        end else begin
            if (cap) begin
                out_data  <= win_data;
                out_src   <= win;
                out_valid <= 1'b1;
`ifdef ARB_LOCK_EN
                // ptr stays put while a lock is taken or held; it moves past
                // the owner only on the final (unlocked) beat
                if (lock[win]) begin
                    locked <= 1'b1;
                    owner  <= win;
                end else begin
                    locked <= 1'b0;
                    ptr    <= inc5(win);
                end
`else
                ptr <= inc5(win);
`endif
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ARB_LOCK_EN
            if (locked && !req[owner]) begin
                locked <= 1'b0;
                ptr    <= inc5(owner);
            end
`endif
        end
    end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed self-checking bench for mux5_rr_arbiter.
module tb_mux5_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  req;
    logic [4:0]  lock;
    logic [15:0] i0, i1, i2, i3, i4;
    logic [4:0]  gnt;
    logic [2:0]  sel;
    logic [15:0] out_data;
    logic [2:0]  out_src;
    logic        out_valid;
    logic        out_ready;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    mux5_rr_arbiter #(.WIDTH(16), .NREQ(5)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .gnt(gnt), .sel(sel), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance past the next rising edge; inputs then change away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned rr_exp [7] = '{0, 1, 2, 3, 4, 0, 1};
        int unsigned lk_exp [5] = '{1, 1, 1, 1, 0};

        reset = 1'b1; req = 5'b11111; lock = '0; out_ready = 1'b1;
        i0 = 16'h1111; i1 = 16'h2222; i2 = 16'hBEEF; i3 = 16'h4444; i4 = 16'h5555;

        // Reset state with all requesters active
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);

        // First grant after reset goes to requester 0
        reset = 1'b0; #1;
        chk("first_gnt", gnt, 5'b00001);
        chk("first_sel", sel, 0);
        tick();
        chk("first_valid", out_valid, 1);
        chk("first_src", out_src, 0);
        chk("first_data", out_data, 16'h1111);

        // Single requester 2, one-cycle latency to the output register
        req = 5'b00100; #1;
        chk("r2_gnt", gnt, 5'b00100);
        chk("r2_sel", sel, 2);
        tick();
        chk("r2_valid", out_valid, 1);
        chk("r2_data", out_data, 16'hBEEF);
        chk("r2_src", out_src, 2);

        // Drain with no refill: valid drops, data held
        req = 5'b00000; #1;
        chk("idle_gnt", gnt, 0);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_data", out_data, 16'hBEEF);

        // Mid-stream reset, then full-rate rotation from ptr = 0
        reset = 1'b1;
        tick();
        reset = 1'b0; req = 5'b11111;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("rr_src%0d", k), out_src, rr_exp[k]);
            chk($sformatf("rr_valid%0d", k), out_valid, 1);
        end

        // Backpressure: ptr = 2, holding word from requester 1
        out_ready = 1'b0; req = 5'b00011;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_gnt%0d", k), gnt, 0);
            chk($sformatf("stall_sel%0d", k), sel, 0);
            tick();
            chk($sformatf("stall_data%0d", k), out_data, 16'h2222);
            chk($sformatf("stall_valid%0d", k), out_valid, 1);
        end
        out_ready = 1'b1; #1;
        chk("resume_gnt", gnt, 5'b00001);
        tick();
        chk("resume_src0", out_src, 0);
        chk("resume_data0", out_data, 16'h1111);
        tick();
        chk("resume_src1", out_src, 1);
        chk("resume_data1", out_data, 16'h2222);

        // Wrap-around: grant 3 leaves ptr = 4, then 4 before 0
        req = 5'b01000; #1;
        chk("w3_gnt", gnt, 5'b01000);
        tick();
        req = 5'b10001; #1;
        chk("w4_gnt", gnt, 5'b10000);
        chk("w4_sel", sel, 4);
        tick();
        chk("w4_src", out_src, 4);
        chk("w4_data", out_data, 16'h5555);
        #1;
        chk("w0_gnt", gnt, 5'b00001);
        tick();
        chk("w0_src", out_src, 0);

        req = 5'b00000;
        tick();
        chk("end_valid", out_valid, 0);

`ifdef ARB_LOCK_EN
        // ptr = 1: three locked beats from 1, unlock beat, then 0
        req = 5'b00011; lock = 5'b00010;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) lock = 5'b00000;
            tick();
            chk($sformatf("lock_src%0d", k), out_src, lk_exp[k]);
        end
        req = 5'b00000;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mux5_rr_arbiter.md
# mux5_rr_arbiter

Round-robin arbiter and output register that shares the 5-input 16-bit source mux between five requesters. It picks one requester per cycle and drives the mux select. It captures the selected word into a registered output with valid/ready backpressure toward the consumer (writeback/result bus). The arbiter never produces a select value above 4, so the mux's undefined select codes are never exercised.

## Interface
Parameters:
- WIDTH, 16, data width of each source and of out_data.
- NREQ, 5, number of requesters; fixed at 5, matching the 3-bit select.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  5  req[k] high: requester k has a valid word on ik.
- lock  input  5  lock[k] high: requester k wants to keep the grant after this beat. Used only with ARB_LOCK_EN.
- i0..i4  input  16 each  source data words.
- gnt  output  5  combinational one-hot; gnt[k] high means ik is captured at this rising edge. All zero when there is no capture.
- sel  output  3  combinational index of the granted requester (0..4); 3'b000 when gnt is all zero.
- out_data  output  16  registered selected word.
- out_src  output  3  registered index of the requester that produced out_data.
- out_valid  output  1  registered; out_data/out_src hold a word.
- out_ready  input  1  consumer accepts out_data this cycle when out_valid is high.

## Operation
- State: ptr (0..4, the highest-priority requester), out_valid, out_data, out_src, plus lock state (see Configuration).
- Slot free: free = !out_valid || out_ready.
- Search: scan req starting at index ptr, ascending, wrapping 4 to 0. The first set bit is winner k.
- Capture: cap = free && |req && !reset. On cap:
  - gnt[k] = 1 and sel = k.
  - Next edge: out_data <= ik, out_src <= k, out_valid <= 1.
  - ptr <= (k == 4) ? 0 : k+1.
- Drain without refill: out_valid && out_ready && !cap sets out_valid <= 0. out_data and out_src hold their last values.
- Stall: out_valid && !out_ready means gnt = 0, sel = 0, and all registers hold.
- Requesters hold req and their data until they see gnt[k]. A req drop before grant is legal and is simply ignored.
- Simultaneous drain and capture: the new word replaces the old in the same edge, so there is no bubble. Full throughput is one word per cycle.
- sel == out_src is never required; sel is a same-cycle mux control, while out_src is the registered tag.

## Timing
- Reset (synchronous, takes effect at the edge where reset=1):
  - ptr = 0, out_valid = 0, out_data = 0, out_src = 0, lock state cleared.
  - gnt = 0 and sel = 0 while reset is high.
- Reset mid-stream discards any held word. No handshake completes in a reset cycle.
- Latency: req[k] high in cycle N with the slot free gives gnt[k] in cycle N and out_valid/out_data in cycle N+1.
- Fairness: with all five requesting continuously and out_ready = 1, grants go 0,1,2,3,4,0,… and each requester waits at most 4 grants.
- gnt and sel depend combinationally on req, out_valid, out_ready, ptr and lock state. There is no combinational path from the data inputs to any control output.

## Configuration
- ARB_LOCK_EN defined:
  - On a capture for k with lock[k] = 1, the arbiter enters locked state with owner = k, and ptr does not advance.
  - While locked, only the owner can win. Other requests are masked.
  - A capture for the owner with lock[owner] = 0 is the last beat: unlock, then ptr <= owner+1 mod 5.
  - Owner req = 0 while locked unlocks at that edge with no grant, and ptr <= owner+1 mod 5.
  - Reset unlocks.
- ARB_LOCK_EN undefined: the lock input is ignored, no lock state is built, and the arbiter is pure round-robin.

## Test plan
- Reset with req = 5'b11111 → gnt = 0, sel = 0, out_valid = 0, out_data = 0, out_src = 0; first grant after reset goes to requester 0.
- req = 5'b00100, i2 = 16'hBEEF, out_ready = 1 → gnt = 5'b00100 and sel = 2 that cycle; next cycle out_valid = 1, out_data = 16'hBEEF, out_src = 2.
- req = 5'b11111 and out_ready = 1 held for 7 cycles → out_src sequence 0,1,2,3,4,0,1 with out_valid continuously high.
- out_valid = 1 and out_ready = 0 held for 3 cycles with req = 5'b00011 → gnt = 0 and out_data stable; when out_ready rises, the next grant goes to ptr's turn, with no word lost or duplicated.
- ptr = 4 after a grant to 3, then req = 5'b10001 → grant 4, then grant 0 (wrap-around).
- With ARB_LOCK_EN: req = 5'b00011, lock[1] = 1 for 3 beats after ptr = 1 → out_src = 1,1,1, then 1 on the unlock beat, then 0.
